// File: rtl/oracle_query_ctrl.sv
// Query controller for a sequential oracle netlist: loads serial test patterns,
// applies them one per gated DUT clock, and streams the captured responses back.
module oracle_query_ctrl #(
   parameter int unsigned NI   = 4,
   parameter int unsigned NCYC = 8,
   parameter int unsigned CW   = 3
) (
   input  logic          CK,
   input  logic          RN,
   input  logic          START,
   input  logic [CW-1:0] LEN,
   input  logic          SI,
   input  logic          SEN,
   output logic [NI-1:0] PI,
   output logic          DUT_CKE,
   input  logic          PO,
   output logic          SO,
   output logic          SOV,
   output logic          BUSY,
   output logic          DONE
);

   localparam int unsigned LW = (NI > 1) ? $clog2(NI) : 1;
   localparam logic [LW-1:0] LANE_LAST = LW'(NI - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      UNLOAD = 2'd3
   } state_e;

   state_e          state_q;
   state_e          state_d;

   logic [CW-1:0]   len_q;
   logic [CW-1:0]   idx_q;
   logic [CW-1:0]   idx_inc;
   logic [LW-1:0]   lane_q;
   logic [NI-1:0]   pat_q [NCYC];
   logic [NCYC-1:0] resp_q;

   logic            start_ok;
   logic            load_last;
   logic            idx_last;
   logic [NI-1:0]   pat0_fwd;

   logic [NI-1:0]   pi_d;
   logic            cke_d;
   logic            so_d;
   logic            sov_d;
   logic            busy_d;
   logic            done_d;

   // A START coinciding with the DONE pulse belongs to the finished query and is dropped.
   assign start_ok  = (state_q == IDLE) && START && !DONE;
   assign load_last = (state_q == LOAD) && SEN && (lane_q == LANE_LAST) && (idx_q == len_q);
   assign idx_last  = (idx_q == len_q);
   assign idx_inc   = idx_q + CW'(1);

   // Pattern 0 as it will look after this edge; for one-cycle queries its last bit is still on SI.
   always_comb begin
      pat0_fwd = pat_q[0];
      if (idx_q == '0) begin
         pat0_fwd[lane_q] = SI;
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)  state_d = LOAD;
         LOAD:    if (load_last) state_d = RUN;
         RUN:     if (idx_last)  state_d = UNLOAD;
         UNLOAD:  if (idx_last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; each takes effect on the edge that changes state.
   always_comb begin
      pi_d   = '0;
      cke_d  = 1'b0;
      so_d   = 1'b0;
      sov_d  = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      case (state_q)
         LOAD: begin
            if (load_last) begin
               pi_d  = pat0_fwd;
               cke_d = 1'b1;
            end
         end
         RUN: begin
            if (!idx_last) begin
               pi_d  = pat_q[idx_inc];
               cke_d = 1'b1;
            end else begin
               sov_d = 1'b1;
               so_d  = (len_q == '0) ? PO : resp_q[0];
            end
         end
         UNLOAD: begin
            if (!idx_last) begin
               sov_d = 1'b1;
               so_d  = resp_q[idx_inc];
            end else begin
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         PI      <= '0;
         DUT_CKE <= 1'b0;
         SO      <= 1'b0;
         SOV     <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         PI      <= pi_d;
         DUT_CKE <= cke_d;
         SO      <= so_d;
         SOV     <= sov_d;
         BUSY    <= busy_d;
         DONE    <= done_d;
      end
   end

   // Buffers and counters; idx_q walks patterns in LOAD, steps in RUN and response bits in UNLOAD.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         len_q  <= '0;
         idx_q  <= '0;
         lane_q <= '0;
         resp_q <= '0;
         for (int i = 0; i < int'(NCYC); i++) begin
            pat_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  len_q  <= LEN;
                  idx_q  <= '0;
                  lane_q <= '0;
               end
            end
            LOAD: begin
               if (SEN) begin
                  pat_q[idx_q][lane_q] <= SI;
                  if (lane_q == LANE_LAST) begin
                     lane_q <= '0;
                     idx_q  <= load_last ? '0 : idx_inc;
                  end else begin
                     lane_q <= lane_q + LW'(1);
                  end
               end
            end
            RUN: begin
               resp_q[idx_q] <= PO;
               idx_q         <= idx_last ? '0 : idx_inc;
            end
            UNLOAD: begin
               idx_q <= idx_last ? '0 : idx_inc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_oracle_query_ctrl.sv
// Bench for oracle_query_ctrl: drives queries into an s27-style oracle and checks
// applied vectors, response stream and timing against a behavioural model.
module tb_oracle_query_ctrl;

   localparam int unsigned NI   = 4;
   localparam int unsigned CW   = 3;
   localparam int unsigned NCYC = 8;

   typedef logic [NI-1:0] pat_t;

   logic          CK = 1'b0;
   logic          RN, START, SEN, SI, PO, DUT_CKE, SO, SOV, BUSY, DONE;
   logic [CW-1:0] LEN;
   logic [NI-1:0] PI;

   int vecs = 0;
   int errs = 0;

   oracle_query_ctrl #(.NI(NI), .NCYC(NCYC), .CW(CW)) dut (
      .CK(CK), .RN(RN), .START(START), .LEN(LEN), .SI(SI), .SEN(SEN),
      .PI(PI), .DUT_CKE(DUT_CKE), .PO(PO), .SO(SO), .SOV(SOV),
      .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CK = ~CK;

   // Oracle instance: s27 netlist (3 flops) or a toggle flop or constant 1, clocked only when DUT_CKE.
   int         po_mode;
   logic       ora_rn;
   logic       tq;
   logic [2:0] st;
   logic       g8, g9, g10, g11, g12, g13, g14, g15, g16;
   assign g14 = ~PI[0];
   assign g12 = ~(PI[1] | st[2]);
   assign g8  = g14 & st[1];
   assign g15 = g12 | g8;
   assign g16 = PI[3] | g8;
   assign g9  = ~(g16 & g15);
   assign g11 = ~(st[0] | g9);
   assign g10 = ~(g14 | g11);
   assign g13 = ~(PI[2] | g12);
   assign PO  = (po_mode == 0) ? 1'b1 : (po_mode == 1) ? tq : ~g11;

   always @(posedge CK) begin
      if (!ora_rn) begin
         st <= 3'b000;
         tq <= 1'b0;
      end else if (DUT_CKE) begin
         st <= {g13, g11, g10};
         tq <= ~tq;
      end
   end

   // Monitor, sampled mid-cycle.
   int          cyc = 0;
   logic [63:0] pi_cat = '0;
   logic [7:0]  so_cat = '0;
   int pi_n = 0, so_n = 0, done_n = 0, done_cyc = -1, leak = 0, busy_bad = 0;
   int cke_first = -1, cke_last = -10, sov_first = -1, sov_last = -10;

   always @(posedge CK) cyc <= cyc + 1;

   always @(negedge CK) begin
      if (DUT_CKE === 1'b1) begin
         if (cke_last != cyc - 1) cke_first = cyc;
         cke_last = cyc;
         pi_cat   = {pi_cat[63-NI:0], PI};
         pi_n++;
      end else if (PI !== '0) begin
         leak++;
      end
      if (SOV === 1'b1) begin
         if (sov_last != cyc - 1) sov_first = cyc;
         sov_last = cyc;
         so_cat   = {so_cat[6:0], SO};
         so_n++;
      end
      if (DONE === 1'b1) begin
         done_n++;
         done_cyc = cyc;
         if (BUSY !== 1'b0 || SOV !== 1'b0) busy_bad++;
      end
   end

   // Reference: s27 next-state/output as boolean equations, plus query-level expectations.
   logic [2:0]  m_st;
   logic        m_t;
   logic [63:0] exp_pi;
   logic [7:0]  exp_so;

   function automatic logic [3:0] s27_ref(input logic [2:0] s, input logic [3:0] v);
      logic a, n11;
      a   = !v[0] && s[1];
      n11 = !s[0] && (v[3] || a) && (!(v[1] || s[2]) || a);
      return {!(v[2] || !(v[1] || s[2])), n11, v[0] && !n11, !n11};
   endfunction

   task automatic model_query(input int n, input pat_t pats[NCYC]);
      logic [3:0] r;
      exp_pi = '0;
      exp_so = '0;
      for (int k = 0; k < n; k++) begin
         exp_pi = (exp_pi << NI) | 64'(pats[k]);
         r      = s27_ref(m_st, pats[k]);
         case (po_mode)
            0:       exp_so = {exp_so[6:0], 1'b1};
            1:       exp_so = {exp_so[6:0], m_t};
            default: exp_so = {exp_so[6:0], r[0]};
         endcase
         m_st = r[3:1];
         m_t  = ~m_t;
      end
   endtask

   int start_cyc;

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic ora_reset();
      ora_rn = 1'b0;
      tick();
      ora_rn = 1'b1;
      m_st   = 3'b000;
      m_t    = 1'b0;
   endtask

   task automatic send_start(input int len);
      tick();
      START     = 1'b1;
      LEN       = CW'(len);
      start_cyc = cyc;
      tick();
      START = 1'b0;
   endtask

   task automatic load_bits(input int n, input pat_t pats[NCYC], input bit gapped, input bit spam);
      for (int j = 0; j < n * int'(NI); j++) begin
         if (gapped) begin
            SEN = 1'b0; SI = 1'($urandom); START = spam;
            tick();
         end
         SEN = 1'b1; SI = pats[j / int'(NI)][j % int'(NI)]; START = spam;
         tick();
      end
      SEN = 1'b0;
   endtask

   task automatic wait_done(input bit spam, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         START = spam;
         SI    = 1'($urandom);
         SEN   = spam ? 1'($urandom) : 1'b0;
         if (DONE === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      SEN = 1'b0;
   endtask

   // Returns #1 after the negedge of the DONE cycle; START keeps its spam value through it.
   task automatic do_query(input int len, input pat_t pats[NCYC], input bit gapped,
                           input bit spam, output bit ok);
      model_query(len + 1, pats);
      send_start(len);
      load_bits(len + 1, pats, gapped, spam);
      wait_done(spam, ok);
      @(negedge CK);
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0; START = 1'b1; SEN = 1'b1; SI = 1'b1; LEN = '1;
      ora_rn = 1'b0; m_st = 3'b000; m_t = 1'b0;
      repeat (3) @(negedge CK);
      vecs++;
      if ({PI, DUT_CKE, SO, SOV, BUSY, DONE} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got %b want 0", {PI, DUT_CKE, SO, SOV, BUSY, DONE});
      end
      tick();
      RN = 1'b1; START = 1'b0; SEN = 1'b0; ora_rn = 1'b1;
      tick();
      tick();
      vecs++;
      if (BUSY !== 1'b0 || DUT_CKE !== 1'b0) begin
         errs++;
         $display("FAIL reset_start_latched: busy=%b cke=%b want 0/0", BUSY, DUT_CKE);
      end
   endtask

   task automatic test_single();
      pat_t p[NCYC];
      bit   ok;
      int   pn0, sn0, dn0;
      p = '{default: '0};
      p[0] = 4'b0101;
      po_mode = 0;
      pn0 = pi_n; sn0 = so_n; dn0 = done_n;
      do_query(0, p, 1'b0, 1'b0, ok);
      vecs++;
      if (!ok || done_cyc != start_cyc + int'(NI) + 3 || done_n - dn0 != 1) begin
         errs++;
         $display("FAIL single_done: latency %0d count %0d want %0d/1", done_cyc - start_cyc, done_n - dn0, NI + 3);
      end
      vecs++;
      if (pi_n - pn0 != 1 || pi_cat[3:0] !== 4'b0101 || cke_first != start_cyc + int'(NI) + 1) begin
         errs++;
         $display("FAIL single_pi: got %h x%0d at +%0d want 5 x1 at +%0d", pi_cat[3:0], pi_n - pn0, cke_first - start_cyc, NI + 1);
      end
      vecs++;
      if (so_n - sn0 != 1 || so_cat[0] !== 1'b1 || sov_first != start_cyc + int'(NI) + 2) begin
         errs++;
         $display("FAIL single_so: got %b x%0d at +%0d want 1 x1 at +%0d", so_cat[0], so_n - sn0, sov_first - start_cyc, NI + 2);
      end
   endtask

   task automatic test_toggle();
      pat_t p[NCYC];
      bit   ok;
      int   pn0, sn0;
      ora_reset();
      po_mode = 1;
      p = '{default: '0};
      p[0] = 4'h1; p[1] = 4'hA; p[2] = 4'hF;
      pn0 = pi_n; sn0 = so_n;
      do_query(2, p, 1'b0, 1'b0, ok);
      vecs++;
      if (!ok || pi_n - pn0 != 3 || cke_last - cke_first != 2) begin
         errs++;
         $display("FAIL toggle_clocks: got %0d enabled (run %0d) want 3", pi_n - pn0, cke_last - cke_first + 1);
      end
      vecs++;
      if (pi_cat[11:0] !== 12'h1AF) begin
         errs++;
         $display("FAIL toggle_pi_seq: got %h want 1af", pi_cat[11:0]);
      end
      vecs++;
      if (so_n - sn0 != 3 || so_cat[2:0] !== 3'b010) begin
         errs++;
         $display("FAIL toggle_so_seq: got %b x%0d want 010 x3", so_cat[2:0], so_n - sn0);
      end
   endtask

   task automatic test_gapped();
      pat_t        p[NCYC];
      bit          ok;
      logic [63:0] pi_ref;
      logic [7:0]  so_ref;
      po_mode = 2;
      p = '{default: '0};
      p[0] = NI'($urandom); p[1] = NI'($urandom);
      ora_reset();
      do_query(1, p, 1'b0, 1'b0, ok);
      pi_ref = pi_cat; so_ref = so_cat;
      ora_reset();
      do_query(1, p, 1'b1, 1'b0, ok);
      vecs++;
      if (!ok || cke_first != start_cyc + 17 || done_cyc != start_cyc + 21) begin
         errs++;
         $display("FAIL gapped_timing: cke at +%0d done at +%0d want +17/+21", cke_first - start_cyc, done_cyc - start_cyc);
      end
      vecs++;
      if (pi_cat[7:0] !== pi_ref[7:0] || pi_cat[7:0] !== exp_pi[7:0]) begin
         errs++;
         $display("FAIL gapped_pi: got %h gapless %h want %h", pi_cat[7:0], pi_ref[7:0], exp_pi[7:0]);
      end
      vecs++;
      if (so_cat[1:0] !== so_ref[1:0] || so_cat[1:0] !== exp_so[1:0]) begin
         errs++;
         $display("FAIL gapped_so: got %b gapless %b want %b", so_cat[1:0], so_ref[1:0], exp_so[1:0]);
      end
   endtask

   task automatic test_start_ignored();
      pat_t p[NCYC];
      bit   ok;
      int   n, dn0;
      po_mode = 2;
      ora_reset();
      n = 3;
      for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
      dn0 = done_n;
      do_query(n - 1, p, 1'b0, 1'b1, ok);
      vecs++;
      if (!ok || done_cyc != start_cyc + n * int'(NI) + 2 * n + 1 || done_n - dn0 != 1) begin
         errs++;
         $display("FAIL spam_done: latency %0d count %0d want %0d/1", done_cyc - start_cyc, done_n - dn0, n * NI + 2 * n + 1);
      end
      vecs++;
      if (pi_cat[11:0] !== exp_pi[11:0] || so_cat[2:0] !== exp_so[2:0]) begin
         errs++;
         $display("FAIL spam_data: pi %h so %b want %h %b", pi_cat[11:0], so_cat[2:0], exp_pi[11:0], exp_so[2:0]);
      end
      tick();
      START = 1'b0;
      vecs++;
      if (BUSY !== 1'b0) begin
         errs++;
         $display("FAIL spam_done_cycle_start: busy=%b want 0", BUSY);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      pat_t p[NCYC];
      bit   ok;
      int   d1, sn0;
      po_mode = 2;
      ora_reset();
      for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
      do_query(1, p, 1'b0, 1'b0, ok);
      d1 = done_cyc;
      for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
      sn0 = so_n;
      do_query(2, p, 1'b0, 1'b0, ok);
      vecs++;
      if (!ok || start_cyc != d1 + 1 || done_cyc != start_cyc + 3 * int'(NI) + 7) begin
         errs++;
         $display("FAIL b2b_accept: start +%0d after done, latency %0d want +1/%0d", start_cyc - d1, done_cyc - start_cyc, 3 * NI + 7);
      end
      vecs++;
      if (pi_cat[11:0] !== exp_pi[11:0] || so_n - sn0 != 3 || so_cat[2:0] !== exp_so[2:0]) begin
         errs++;
         $display("FAIL b2b_data: pi %h so %b x%0d want %h %b x3", pi_cat[11:0], so_cat[2:0], so_n - sn0, exp_pi[11:0], exp_so[2:0]);
      end
   endtask

   task automatic test_full_and_random();
      pat_t        p[NCYC];
      bit          ok, g, s;
      int          len, n, ld, pn0, sn0;
      logic [63:0] pm;
      logic [7:0]  sm;
      po_mode = 2;
      ora_reset();
      for (int q = 0; q < 14; q++) begin
         len = (q == 0) ? int'(NCYC) - 1 : int'($urandom_range(0, NCYC - 1));
         g   = (q == 0) ? 1'b0 : 1'($urandom);
         s   = (q == 0) ? 1'b0 : 1'($urandom);
         n   = len + 1;
         ld  = g ? 2 * n * int'(NI) : n * int'(NI);
         pm  = (64'd1 << (n * int'(NI))) - 64'd1;
         sm  = 8'((16'd1 << n) - 16'd1);
         for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
         pn0 = pi_n; sn0 = so_n;
         do_query(len, p, g, s, ok);
         vecs++;
         if (!ok || done_cyc != start_cyc + ld + 2 * n + 1) begin
            errs++;
            $display("FAIL rand%0d_done: latency %0d want %0d", q, done_cyc - start_cyc, ld + 2 * n + 1);
         end
         vecs++;
         if (pi_n - pn0 != n || cke_first != start_cyc + ld + 1 || cke_last != cke_first + n - 1
             || (pi_cat & pm) !== exp_pi) begin
            errs++;
            $display("FAIL rand%0d_pi: got %h x%0d at +%0d want %h x%0d at +%0d", q, pi_cat & pm,
                     pi_n - pn0, cke_first - start_cyc, exp_pi, n, ld + 1);
         end
         vecs++;
         if (so_n - sn0 != n || sov_first != start_cyc + ld + n + 1 || (so_cat & sm) !== exp_so) begin
            errs++;
            $display("FAIL rand%0d_so: got %b x%0d at +%0d want %b x%0d at +%0d", q, so_cat & sm,
                     so_n - sn0, sov_first - start_cyc, exp_so, n, ld + n + 1);
         end
      end
      tick();
      START = 1'b0;
      tick();
      vecs++;
      if (leak != 0 || busy_bad != 0) begin
         errs++;
         $display("FAIL idle_outputs: pi leak %0d, busy/sov in done %0d want 0/0", leak, busy_bad);
      end
   endtask

   task automatic test_reset_mid();
      pat_t p[NCYC];
      bit   ok;
      int   dn0;
      po_mode = 2;
      ora_reset();
      for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
      send_start(int'(NCYC) - 1);
      load_bits(int'(NCYC), p, 1'b0, 1'b0);
      tick();
      tick();
      vecs++;
      if (DUT_CKE !== 1'b1 || BUSY !== 1'b1) begin
         errs++;
         $display("FAIL midrst_running: cke=%b busy=%b want 1/1", DUT_CKE, BUSY);
      end
      dn0 = done_n;
      #2 RN = 1'b0;
      #1;
      vecs++;
      if ({PI, DUT_CKE, SO, SOV, BUSY, DONE} !== '0) begin
         errs++;
         $display("FAIL midrst_async: got %b want 0", {PI, DUT_CKE, SO, SOV, BUSY, DONE});
      end
      repeat (4) tick();
      RN = 1'b1;
      repeat (40) tick();
      vecs++;
      if (done_n != dn0) begin
         errs++;
         $display("FAIL midrst_no_done: got %0d pulses want 0", done_n - dn0);
      end
      ora_reset();
      for (int k = 0; k < int'(NCYC); k++) p[k] = NI'($urandom);
      do_query(1, p, 1'b0, 1'b0, ok);
      vecs++;
      if (!ok || done_cyc != start_cyc + 2 * int'(NI) + 5 || pi_cat[7:0] !== exp_pi[7:0]
          || so_cat[1:0] !== exp_so[1:0]) begin
         errs++;
         $display("FAIL midrst_after: latency %0d pi %h so %b want %0d %h %b", done_cyc - start_cyc,
                  pi_cat[7:0], so_cat[1:0], 2 * NI + 5, exp_pi[7:0], exp_so[1:0]);
      end
   endtask

   initial begin
      RN = 1'b0; START = 1'b0; SEN = 1'b0; SI = 1'b0; LEN = '0;
      ora_rn = 1'b0; po_mode = 0; m_st = 3'b000; m_t = 1'b0;
      test_reset();
      test_single();
      test_toggle();
      test_gapped();
      test_start_ignored();
      test_back_to_back();
      test_full_and_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
